// File: rtl/frog_tracker.sv
// Frog position/state tracker: debounced button moves, lane collision detect, win flag.
// Optional FROG_COLLISION_FILTER_EN: require two consecutive overlap cycles before HIT.
`timescale 1ns/1ps
module frog_tracker #(
    parameter int WIDTH     = 16,
    parameter int LANES     = 8,
    parameter int START_COL = 7,
    localparam int RW = $clog2(LANES+2),
    localparam int CW = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic [LANES*WIDTH-1:0] lane_pixels,
    output logic [RW-1:0]          frog_row,
    output logic [CW-1:0]          frog_col,
    output logic [WIDTH-1:0]       frog_pixels,
    output logic                   hit,
    output logic                   win
);

    typedef enum logic [1:0] {PLAY, HIT, WIN} state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            hit_q, win_q;
    logic [3:0]      sync1_q, sync2_q, prev_q;
    logic [3:0]      rise;
    logic            mv_up, mv_down, mv_left, mv_right;
    logic [WIDTH-1:0] lane_sel;
    logic            overlap, collide;

    // bit 0 = up .. bit 3 = right; lower index wins arbitration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {btn_right, btn_left, btn_down, btn_up};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise     = sync2_q & ~prev_q;
    assign mv_up    = rise[0];
    assign mv_down  = rise[1] & ~rise[0];
    assign mv_left  = rise[2] & ~|rise[1:0];
    assign mv_right = rise[3] & ~|rise[2:0];

    // Start and goal rows select no lane, so they read as empty.
    always_comb begin
        lane_sel = '0;
        for (int r = 1; r <= LANES; r++) begin
            if (row_q == RW'(r)) lane_sel = lane_pixels[(r-1)*WIDTH +: WIDTH];
        end
    end
    assign overlap = lane_sel[col_q];

`ifdef FROG_COLLISION_FILTER_EN
    logic pending_q;
    logic any_move;
    assign any_move = |rise;
    assign collide  = overlap & pending_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending_q <= 1'b0;
        else       pending_q <= (state_q == PLAY) & overlap & ~any_move;
    end
`else
    assign collide = overlap;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            PLAY: begin
                if (collide) begin
                    state_d = HIT;
                end else if (mv_up) begin
                    row_d = row_q + RW'(1);
                    if (row_q == RW'(LANES)) state_d = WIN;
                end else if (mv_down) begin
                    if (row_q != '0) row_d = row_q - RW'(1);
                end else if (mv_left) begin
                    if (col_q != '0) col_d = col_q - CW'(1);
                end else if (mv_right) begin
                    if (col_q != CW'(WIDTH-1)) col_d = col_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PLAY;
            row_q   <= '0;
            col_q   <= CW'(START_COL);
            hit_q   <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            hit_q   <= (state_d == HIT);
            win_q   <= (state_d == WIN);
        end
    end

    always_comb begin
        frog_pixels = '0;
        if (state_q != WIN) frog_pixels[col_q] = 1'b1;
    end

    assign frog_row = row_q;
    assign frog_col = col_q;
    assign hit      = hit_q;
    assign win      = win_q;

endmodule

// File: tb/tb_frog_tracker.sv
// Directed bench for frog_tracker: vector table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_frog_tracker;

    localparam int WIDTH = 16;
    localparam int LANES = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [LANES*WIDTH-1:0] lane_pixels = '0;
    logic [3:0]             frog_row;
    logic [3:0]             frog_col;
    logic [WIDTH-1:0]       frog_pixels;
    logic                   hit, win;

    int ntests = 0;
    int nfail  = 0;

    frog_tracker #(.WIDTH(WIDTH), .LANES(LANES), .START_COL(7)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .lane_pixels(lane_pixels),
        .frog_row(frog_row), .frog_col(frog_col), .frog_pixels(frog_pixels),
        .hit(hit), .win(win)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]             btn;   // {right,left,down,up}
        logic [LANES*WIDTH-1:0] lanes;
        int                     row;
        int                     col;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_pos(input string name, input int row, input int col);
        chk({name, " row"}, 32'(frog_row), 32'(row));
        chk({name, " col"}, 32'(frog_col), 32'(col));
    endtask

    task automatic press(input logic [3:0] b);
        @(negedge clk);
        {btn_right, btn_left, btn_down, btn_up} = b;
        @(negedge clk);
        {btn_right, btn_left, btn_down, btn_up} = 4'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] onehot;

        tbl[0] = '{4'b0010, {LANES*WIDTH{1'b1}}, 0, 7};   // down at row 0, cars ignored on start row
        tbl[1] = '{4'b0100, '0, 0, 6};
        tbl[2] = '{4'b1000, '0, 0, 7};
        tbl[3] = '{4'b1001, '0, 1, 7};                    // up beats right
        tbl[4] = '{4'b0001, '0, 2, 7};
        tbl[5] = '{4'b0110, '0, 1, 7};                    // down beats left
        tbl[6] = '{4'b1100, '0, 1, 6};                    // left beats right
        tbl[7] = '{4'b1000, '0, 1, 7};
        tbl[8] = '{4'b0000, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0080_FF7F, 1, 7};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_pos("reset", 0, 7);
        chk("reset pixels", 32'(frog_pixels), 32'h0080);
        chk("reset hit", 32'(hit), 0);
        chk("reset win", 32'(win), 0);

        for (int i = 0; i < 9; i++) begin
            lane_pixels = tbl[i].lanes;
            press(tbl[i].btn);
            chk_pos($sformatf("vec%0d", i), tbl[i].row, tbl[i].col);
            onehot = 32'd1 << tbl[i].col;
            chk($sformatf("vec%0d pixels", i), 32'(frog_pixels), onehot);
            chk($sformatf("vec%0d hit", i), 32'(hit), 0);
            chk($sformatf("vec%0d win", i), 32'(win), 0);
        end
        lane_pixels = '0;

        // left saturation, then right saturation
        do_reset();
        for (int i = 0; i < 8; i++) begin
            press(4'b0100);
            chk($sformatf("left%0d col", i), 32'(frog_col), (i < 7) ? 32'(6 - i) : 32'd0);
        end
        repeat (20) press(4'b1000);
        chk_pos("right sat", 0, 15);
        press(4'b0001);
        chk_pos("pre async", 1, 15);

        // asynchronous reset mid-cycle
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk_pos("async reset", 0, 7);
        chk("async pixels", 32'(frog_pixels), 32'h0080);
        chk("async hit", 32'(hit), 0);
        chk("async win", 32'(win), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // held button: one move exactly at E+2
        btn_up = 1'b1;
        @(posedge clk); #1;
        chk("hold E row", 32'(frog_row), 0);
        @(posedge clk); #1;
        chk("hold E+1 row", 32'(frog_row), 0);
        @(posedge clk); #1;
        chk("hold E+2 row", 32'(frog_row), 1);
        repeat (47) @(posedge clk);
        #1;
        chk("hold end row", 32'(frog_row), 1);
        @(negedge clk);
        btn_up = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold release row", 32'(frog_row), 1);

        // collision latency at row 1 col 3
        do_reset();
        press(4'b0001);
        repeat (4) press(4'b0100);
        chk_pos("coll setup", 1, 3);
        chk("coll pre hit", 32'(hit), 0);
        lane_pixels = 128'h0008;
        @(posedge clk); #1;
`ifdef FROG_COLLISION_FILTER_EN
        chk("filt 1cyc hit", 32'(hit), 0);
        @(negedge clk);
        lane_pixels = '0;
        repeat (3) @(negedge clk);
        chk("filt 1cyc later", 32'(hit), 0);
        lane_pixels = 128'h0008;
        @(posedge clk); #1;
        chk("filt 2cyc edge1", 32'(hit), 0);
        @(posedge clk); #1;
        chk("filt 2cyc edge2", 32'(hit), 1);
`else
        chk("coll hit", 32'(hit), 1);
`endif
        @(negedge clk);
        lane_pixels = '0;
        press(4'b0001);
        press(4'b0100);
        chk_pos("hit frozen", 1, 3);
        chk("hit sticky", 32'(hit), 1);
        chk("hit no win", 32'(win), 0);
        chk("hit pixels", 32'(frog_pixels), 32'h0008);

        // win after 9 ups with clear lanes
        do_reset();
        repeat (9) press(4'b0001);
        chk("win row", 32'(frog_row), 9);
        chk("win flag", 32'(win), 1);
        chk("win hit", 32'(hit), 0);
        chk("win pixels", 32'(frog_pixels), 0);
        press(4'b0010);
        press(4'b0100);
        chk_pos("win frozen", 9, 7);
        chk("win sticky", 32'(win), 1);

        // move and overlap in the same cycle
        do_reset();
        press(4'b0001);
        press(4'b0001);
        chk_pos("mvc setup", 2, 7);
        btn_up = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        lane_pixels = '0;
        lane_pixels[WIDTH + 7] = 1'b1;
        @(posedge clk); #1;
`ifdef FROG_COLLISION_FILTER_EN
        chk("mvc row", 32'(frog_row), 3);
        chk("mvc hit", 32'(hit), 0);
`else
        chk("mvc row", 32'(frog_row), 2);
        chk("mvc hit", 32'(hit), 1);
`endif
        @(negedge clk);
        btn_up = 1'b0;
        lane_pixels = '0;
        repeat (3) @(negedge clk);
`ifdef FROG_COLLISION_FILTER_EN
        chk("mvc later row", 32'(frog_row), 3);
`else
        chk("mvc later row", 32'(frog_row), 2);
        chk("mvc later hit", 32'(hit), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
